align_shift_seq: RTL and testbench

ALIGN_SHIFT_SEQ -- requirements
Module: align_shift_seq

---
 rtl/align_shift_seq.sv | 213 +++++++++++++++++++++
 tb/tb_align_shift_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/align_shift_seq.sv
// ----------------------------------------------------------------------------
// align_shift_seq
//
// Sequential significand alignment for a floating-point adder. One operand
// set is accepted at a time. The significand belonging to the larger
// exponent passes straight through. The other significand is widened with
// guard/round/sticky bits and shifted right by the exponent difference,
// STEP bits per clock. Every bit shifted out below bit 0 is ORed into the
// sticky bit.
//
// Parameters
//   MW    significand width including hidden bit (default 53)
//   EW    exponent width (default 11)
//   STEP  right-shift bits per SHIFT cycle: 1, 2, 4 or 8 (default 4)
//
// Optional feature
//   ALIGN_FAST_SKIP_EN  when defined, a fully saturated shift (difference
//                       >= MW+2) completes in one cycle instead of iterating.
//                       The aligned result is bit-identical; only latency
//                       changes.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set present
//   in_ready   block can accept an operand set (high only when idle)
//   fa, fb     significands of operands A and B
//   ea, eb     exponents of operands A and B
//   eb_gt_ea   eb > ea, from the exponent subtractor
//   as         |ea - eb|, from the exponent subtractor
//   out_valid  aligned result present
//   out_ready  consumer accepts the result
//   fx_out     larger-exponent significand, {fx, 3'b000}
//   fy_out     aligned smaller-exponent significand, {sig, guard, round, sticky}
//   e_out      result exponent, max(ea, eb)
//   swap_out   registered eb_gt_ea
// ----------------------------------------------------------------------------
module align_shift_seq #(
  parameter int MW   = 53,
  parameter int EW   = 11,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   fa,
  input  logic [MW-1:0]   fb,
  input  logic [EW-1:0]   ea,
  input  logic [EW-1:0]   eb,
  input  logic            eb_gt_ea,
  input  logic [EW-1:0]   as,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MW+2:0]   fx_out,
  output logic [MW+2:0]   fy_out,
  output logic [EW-1:0]   e_out,
  output logic            swap_out
);

  // Working word width and the largest meaningful shift: beyond MW+2 every
  // significand bit has already collapsed into sticky.
  localparam int YW  = MW + 3;
  localparam int SAT = MW + 2;
  localparam int RW  = $clog2(MW + 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [MW-1:0]   fx_q;
  logic [EW-1:0]   e_q;
  logic            swap_q;
  logic [YW-1:0]   y;
  logic [RW-1:0]   rem;

  logic            accept;
  logic [MW-1:0]   fx_sel;
  logic [MW-1:0]   fy_sel;
  logic [EW-1:0]   e_sel;
  logic [RW-1:0]   rem_load;
  logic [RW-1:0]   k;
  logic            fast_skip;

  // Clamp the exponent difference to the saturation point.
  function automatic logic [RW-1:0] sat_rem(input logic [EW-1:0] d);
    logic [31:0] dw;
    dw = 32'(d);
    if (dw > 32'(SAT)) begin
      sat_rem = RW'(SAT);
    end else begin
      sat_rem = RW'(dw);
    end
  endfunction

  // Bits shifted this cycle: a full STEP, or whatever is left.
  function automatic logic [RW-1:0] step_k(input logic [RW-1:0] r);
    if (32'(r) > 32'(STEP)) begin
      step_k = RW'(STEP);
    end else begin
      step_k = r;
    end
  endfunction

  // Right shift by kk with sticky: every bit that falls off the bottom,
  // including the old bit 0, is ORed into the new bit 0.
  function automatic logic [YW-1:0] shift_sticky(input logic [YW-1:0] w,
                                                 input logic [RW-1:0] kk);
    logic [YW-1:0] mask;
    logic          lost;
    mask = '0;
    for (int i = 0; i < YW; i++) begin
      if (i < int'(kk)) begin
        mask[i] = 1'b1;
      end
    end
    lost            = |(w & mask);
    shift_sticky    = w >> kk;
    shift_sticky[0] = shift_sticky[0] | lost;
  endfunction

  assign accept   = (state == IDLE) && in_valid;
  assign fx_sel   = eb_gt_ea ? fb : fa;
  assign fy_sel   = eb_gt_ea ? fa : fb;
  assign e_sel    = eb_gt_ea ? eb : ea;
  assign rem_load = sat_rem(as);
  assign k        = step_k(rem);

`ifdef ALIGN_FAST_SKIP_EN
  // A saturated shift always ends as {0..0, |fy}; produce it directly.
  assign fast_skip = accept && (rem_load == RW'(SAT));
`else
  assign fast_skip = 1'b0;
`endif

  // ---- control: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- control: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((rem_load == '0) || fast_skip) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        // rem reaches zero on this edge
        if (rem == k) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE takes the cycle; nothing is accepted during it.
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- datapath: capture on accept, shift while in SHIFT ----
  // Registers only move on accept or in SHIFT, so every output holds while
  // DONE waits for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      fx_q   <= '0;
      e_q    <= '0;
      swap_q <= 1'b0;
      y      <= '0;
      rem    <= '0;
    end else if (accept) begin
      fx_q   <= fx_sel;
      e_q    <= e_sel;
      swap_q <= eb_gt_ea;
      if (fast_skip) begin
        y   <= {{(YW-1){1'b0}}, |fy_sel};
        rem <= '0;
      end else begin
        y   <= {fy_sel, 3'b000};
        rem <= rem_load;
      end
    end else if (state == SHIFT) begin
      y   <= shift_sticky(y, k);
      rem <= rem - k;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign fx_out    = {fx_q, 3'b000};
  assign fy_out    = y;
  assign e_out     = e_q;
  assign swap_out  = swap_q;

endmodule

// File: tb/tb_align_shift_seq.sv
// ----------------------------------------------------------------------------
// tb_align_shift_seq
//
// Directed bench for align_shift_seq (MW=53, EW=11, STEP=4). A transaction
// level reference model derives the expected outputs from the alignment
// rules (one-shot shift with sticky, latency from the shift distance); a
// compare process checks the DUT against it every cycle. Directed scenarios
// also pin hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_align_shift_seq;

  localparam int MW   = 53;
  localparam int EW   = 11;
  localparam int STEP = 4;
  localparam int YW   = MW + 3;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [MW-1:0]   fa;
  logic [MW-1:0]   fb;
  logic [EW-1:0]   ea;
  logic [EW-1:0]   eb;
  logic            eb_gt_ea;
  logic [EW-1:0]   as;
  logic            out_valid;
  logic            out_ready;
  logic [YW-1:0]   fx_out;
  logic [YW-1:0]   fy_out;
  logic [EW-1:0]   e_out;
  logic            swap_out;

  int errs   = 0;
  int checks = 0;

  align_shift_seq #(.MW(MW), .EW(EW), .STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fa        (fa),
    .fb        (fb),
    .ea        (ea),
    .eb        (eb),
    .eb_gt_ea  (eb_gt_ea),
    .as        (as),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fx_out    (fx_out),
    .fy_out    (fy_out),
    .e_out     (e_out),
    .swap_out  (swap_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Aligned value of fy for a difference of asv: one shift of the whole
  // distance, with any nonzero bit that leaves the word forcing sticky.
  function automatic logic [YW-1:0] model_fy(input logic [MW-1:0] fyv, input int asv);
    int            sh;
    logic [YW-1:0] full;
    logic [YW-1:0] res;
    logic          lost;
    sh   = (asv > MW + 2) ? MW + 2 : asv;
    full = {fyv, 3'b000};
    lost = (sh == 0) ? 1'b0 : |(full << (YW - sh));
    res  = full >> sh;
    res[0] = res[0] | lost;
    return res;
  endfunction

  function automatic int model_lat(input int asv);
    int sh;
    sh = (asv > MW + 2) ? MW + 2 : asv;
    if (sh == 0) return 1;
`ifdef ALIGN_FAST_SKIP_EN
    if (sh == MW + 2) return 1;
`endif
    return 1 + (sh + STEP - 1) / STEP;
  endfunction

  // Reference model: 0 = idle, 1 = busy (counting down), 2 = result held.
  int              m_st   = 0;
  int              m_cnt  = 0;
  bit              m_init = 1'b0;
  bit              m_fy_known = 1'b0;
  logic [YW-1:0]   e_fx;
  logic [YW-1:0]   e_fy;
  logic [EW-1:0]   e_e;
  logic            e_sw;

  always @(posedge clk) begin
    int lat;
    if (rst) begin
      m_init     <= 1'b1;
      m_st       <= 0;
      m_cnt      <= 0;
      m_fy_known <= 1'b1;
      e_fx <= '0; e_fy <= '0; e_e <= '0; e_sw <= 1'b0;
    end else if (m_init) begin
      case (m_st)
        0: if (in_valid) begin
          lat = model_lat(int'(as));
          e_fx <= {(eb_gt_ea ? fb : fa), 3'b000};
          e_fy <= model_fy(eb_gt_ea ? fa : fb, int'(as));
          e_e  <= eb_gt_ea ? eb : ea;
          e_sw <= eb_gt_ea;
          m_fy_known <= 1'b0;
          if (lat == 1) m_st <= 2;
          else begin m_st <= 1; m_cnt <= lat - 1; end
        end
        1: begin
          if (m_cnt == 1) m_st <= 2;
          m_cnt <= m_cnt - 1;
        end
        default: if (out_ready) m_st <= 0;
      endcase
    end
  end

  // Compare process: away from the active edge.
  always @(negedge clk) begin
    if (m_init && !rst) begin
      chk("in_ready",  64'(in_ready),  64'(m_st == 0));
      chk("out_valid", 64'(out_valid), 64'(m_st == 2));
      chk("fx_out",    64'(fx_out),    64'(e_fx));
      chk("e_out",     64'(e_out),     64'(e_e));
      chk("swap_out",  64'(swap_out),  64'(e_sw));
      if (m_st == 2 || m_fy_known) chk("fy_out", 64'(fy_out), 64'(e_fy));
    end
  end

  // Present an operand set in idle, return cycles from accept edge to valid.
  task automatic txn(input logic [MW-1:0] fav, input logic [MW-1:0] fbv,
                     input logic [EW-1:0] eav, input logic [EW-1:0] ebv,
                     input logic swv, input logic [EW-1:0] asv, output int lat);
    fa = fav; fb = fbv; ea = eav; eb = ebv; eb_gt_ea = swv; as = asv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("txn_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [MW-1:0] tfx [8];
  logic [MW-1:0] tfy [8];
  int            tas [8];

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fa = '0; fb = '0; ea = '0; eb = '0; eb_gt_ea = 1'b0; as = '0;
    tfx[0] = 53'h10_0000_0000_0000; tfy[0] = 53'h1F_FFFF_FFFF_FFFF; tas[0] = 1;
    tfx[1] = 53'h1A_BCDE_F012_3456; tfy[1] = 53'h15_5555_5555_5555; tas[1] = 3;
    tfx[2] = 53'h1F_0000_0000_0001; tfy[2] = 53'h10_0000_0000_0010; tas[2] = 5;
    tfx[3] = 53'h12_3456_789A_BCDE; tfy[3] = 53'h10_0000_0000_0080; tas[3] = 8;
    tfx[4] = 53'h10_0000_0000_0000; tfy[4] = 53'h1F_FFFF_FFFF_FFFF; tas[4] = 54;
    tfx[5] = 53'h18_0000_0000_0000; tfy[5] = 53'h10_0000_0000_0000; tas[5] = 55;
    tfx[6] = 53'h11_1111_1111_1111; tfy[6] = 53'h10_0000_0000_0001; tas[6] = 56;
    tfx[7] = 53'h1C_0000_0000_0000; tfy[7] = 53'h00_0000_0000_0000; tas[7] = 30;
    repeat (3) @(negedge clk);
    // reset state, sampled while rst is still high
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fy_out",    64'(fy_out),    64'd0);
    rst = 1'b0;
    @(negedge clk);

    // equal exponents, no shift
    txn(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 11'd5, 11'd5, 1'b0, 11'd0, lat);
    chk("r036_lat", 64'(lat), 64'd1);
    chk("r036_fx",  64'(fx_out), 64'h0080_0000_0000_0000);
    chk("r036_fy",  64'(fy_out), 64'h0080_0000_0000_0000);
    chk("r036_e",   64'(e_out),  64'd5);
    release_out();

    // B larger, one STEP of shift with sticky
    txn(53'h10_0000_0000_0001, 53'h10_0000_0000_0003, 11'd6, 11'd10, 1'b1, 11'd4, lat);
    chk("r037_lat",  64'(lat), 64'd2);
    chk("r037_fy",   64'(fy_out), 64'h0008_0000_0000_0001);
    chk("r037_fx",   64'(fx_out), 64'h0080_0000_0000_0018);
    chk("r037_e",    64'(e_out),  64'd10);
    chk("r037_swap", 64'(swap_out), 64'd1);
    release_out();

    // fully saturated difference
    txn(53'h10_0000_0000_0000, 53'h00_0000_0000_0001, 11'd2047, 11'd0, 1'b0, 11'd2047, lat);
    chk("r038_fy", 64'(fy_out), 64'd1);
`ifdef ALIGN_FAST_SKIP_EN
    chk("r038_lat", 64'(lat), 64'd1);
`else
    chk("r038_lat", 64'(lat), 64'd15);
`endif
    release_out();

    // directed table, alternating which operand is larger
    for (int i = 0; i < 8; i++) begin
      logic sw;
      sw = i[0];
      txn(sw ? tfy[i] : tfx[i], sw ? tfx[i] : tfy[i],
          sw ? 11'd1000 : 11'd1100, sw ? 11'd1100 : 11'd1000, sw, EW'(tas[i]), lat);
      chk("tab_lat", 64'(lat), 64'(model_lat(tas[i])));
      release_out();
    end

    // hold off the consumer; in_valid must be ignored meanwhile
    txn(53'h10_0000_0000_0007, 53'h10_0000_0000_0009, 11'd20, 11'd20, 1'b0, 11'd0, lat);
    fa = 53'h1F_0000_0000_0000; fb = 53'h1F_0000_0000_0000; as = 11'd8; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("r039_in_ready", 64'(in_ready), 64'd0);
      chk("r039_fy_hold",  64'(fy_out),   64'h0080_0000_0000_0048);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("r039_idle_rdy", 64'(in_ready),  64'd1);
    chk("r039_idle_vld", 64'(out_valid), 64'd0);
    @(negedge clk);

    // reset during the third SHIFT cycle
    fa = 53'h10_0000_0000_00FF; fb = 53'h1E_0000_0000_0000; ea = 11'd100; eb = 11'd120;
    eb_gt_ea = 1'b1; as = 11'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r040_in_ready", 64'(in_ready),  64'd1);
    chk("r040_valid",    64'(out_valid), 64'd0);
    chk("r040_fx",       64'(fx_out),    64'd0);
    chk("r040_fy",       64'(fy_out),    64'd0);
    chk("r040_e",        64'(e_out),     64'd0);
    chk("r040_swap",     64'(swap_out),  64'd0);
    repeat (6) @(negedge clk);
    txn(53'h10_0000_0000_0002, 53'h10_0000_0000_0004, 11'd3, 11'd3, 1'b0, 11'd0, lat);
    chk("r040_fresh_lat", 64'(lat), 64'd1);
    chk("r040_fresh_fy",  64'(fy_out), 64'h0080_0000_0000_0020);
    release_out();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
